alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Upstream issue stage for `alu_simple`. It accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO. It drives the head command onto the ALU operand and select lines, then registers the combinational ALU result into a valid/ready output stage. This gives the purely combinational ALU a clocked, back-pressured pipeline slot in the datapath.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width; must match `alu_simple`.
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  upstream command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_a`, `cmd_b`  in  `WIDTH`  operands.
- `cmd_sel`  in  2  opcode: 00 add, 01 sub, 10 and, 11 or.
- `alu_a`, `alu_b`  out  `WIDTH`  to `alu_simple` a/b.
- `alu_sel`  out  2  to `alu_simple` sel.
- `alu_y`  in  `WIDTH`  from `alu_simple` y; combinational.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  downstream accepts result.
- `res_y`  out  `WIDTH`  registered result.
- `res_sel`  out  2  opcode that produced `res_y`.
- `count`  out  $clog2(`DEPTH`)+1  FIFO occupancy, excluding the result register.

## Operation
- FIFO:
  - Circular buffer with write and read pointers of $clog2(`DEPTH`) bits each; pointers wrap modulo `DEPTH`.
  - `count` tracks occupancy.
- `cmd_ready = (count != DEPTH)`; purely from state, with no combinational path from `res_ready`.
- A push when full is impossible. A pop in the same cycle does not free space for a push in that cycle.
- ALU drive:
  - When `count > 0`, `alu_a/alu_b/alu_sel` are the head entry's fields.
  - When the FIFO is empty they are driven to 0.
- The output register FSM has two states:
  - EMPTY: `res_valid` = 0. If `count > 0`, capture `alu_y`/`alu_sel` into `res_y`/`res_sel`, pop the head, and go to FULL.
  - FULL: `res_valid` = 1; `res_y` and `res_sel` are held stable.
    - On `res_ready` = 1 with `count > 0`: capture the next result and pop, staying in FULL.
    - On `res_ready` = 1 with `count == 0`: go to EMPTY.
    - On `res_ready` = 0: hold, with no pop.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Arithmetic is performed by `alu_simple`: modulo 2^`WIDTH`, with carry and borrow discarded. This block does no width extension.
- Reset (asynchronous, at any time including mid-transfer):
  - Pointers, `count`, `res_valid`, `res_y` and `res_sel` are cleared to 0.
  - FSM returns to EMPTY and FIFO contents are discarded.
  - `cmd_ready` = 1; ALU drive = 0.

## Timing
- Latency: a command accepted at edge N, with the FIFO empty and the result register free, presents `res_valid` = 1 and its result after edge N+1.
- Throughput: one command per cycle sustained while `res_ready` = 1.
- Capacity: with `res_ready` held low, `DEPTH`+1 commands are absorbed (`DEPTH` in the FIFO, 1 in the result register) before `cmd_ready` falls.
- `res_*` changes only on a rising edge where EMPTY→FULL occurs or `res_ready` = 1.
- `alu_y` must settle within one clock period of the head changing; the single-cycle path runs FIFO head → ALU → result register.

## Configuration
- Macro `ALU_ISSUE_FLAGS_EN`.
  - Defined: adds outputs `res_zero` (1 when `res_y` == 0) and `res_neg` (`res_y[WIDTH-1]`). Both are registered alongside `res_y`, held with it, and reset to 0.
  - Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_AND`=2'b10, `ALU_OR`=2'b11.
  - Default `ALU_WIDTH`=16.
  - Output FSM state encoding, EMPTY/FULL.
- Sub-module `alu_cmd_fifo` holds the storage, pointers and count, with a `{sel,b,a}` packed entry.
- The top level contains the output FSM and result register. `alu_simple` is instantiated by the parent, not inside this block.

## Test plan
- a=15, b=4, sel=00,01,10,11 issued back-to-back with `res_ready`=1 → `res_y` = 19, 11, 4, 15 on consecutive cycles; the first result is valid 2 edges after the first accept.
- a=0x0F0F, b=0x00FF, sel=00 → `res_y`=0x100E; then a=0x0000, b=0x0001, sel=01 → `res_y`=0xFFFF, demonstrating wrap.
- `res_ready`=0 while streaming → 5 commands accepted, `count`=4, `cmd_ready`=0. Each `res_ready` pulse then releases results in issue order and re-raises `cmd_ready` one cycle later.
- `rst_n` asserted low with 3 entries queued and `res_valid`=1 → all outputs 0 immediately, `cmd_ready`=1; the next command after release returns its result with the normal 2-edge latency.
- With `ALU_ISSUE_FLAGS_EN`: 5−5 → `res_zero`=1, `res_neg`=0; 0−1 → `res_zero`=0, `res_neg`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, default datapath
// width and the result-register FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [0:0] RES_EMPTY = 1'b0;
    localparam logic [0:0] RES_FULL  = 1'b1;

endpackage : alu_pkg

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_issue_stage: circular buffer of packed {sel,b,a}
// entries with wrapping read/write pointers and an occupancy count.
//   clk, rst_n        : clock, async active-low reset
//   push, push_entry  : write an entry (caller guarantees not full)
//   pop               : drop the head (caller guarantees not empty)
//   head              : entry at the read pointer (undefined when empty)
//   count             : occupancy, 0..DEPTH
module alu_cmd_fifo #(
    parameter int unsigned ENTRY_W = 34,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_entry,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale contents are never visible once count is cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : alu_cmd_fifo

// File: rtl/alu_issue_stage.sv
// Issue stage for alu_simple: buffers commands in a FIFO, drives the head
// onto the ALU, and registers the ALU result into a valid/ready slot.
// Optional macro ALU_ISSUE_FLAGS_EN adds registered res_zero/res_neg flags.
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel : command input handshake
//   alu_a/alu_b/alu_sel -> alu_simple, alu_y <- alu_simple (combinational)
//   res_valid/res_ready/res_y/res_sel       : registered result handshake
//   count                                   : FIFO occupancy (excl. result reg)
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [1:0]             cmd_sel,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [1:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_y,
    output logic [1:0]             res_sel,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic                   res_zero,
    output logic                   res_neg
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = 2 * WIDTH + 2;

    logic          fifo_push;
    logic          fifo_pop;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic [CW-1:0] fifo_count;
    logic          head_valid;
    logic          capture;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic [1:0]       res_sel_q, res_sel_d;

    alu_cmd_fifo #(
        .ENTRY_W (EW),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .count      (fifo_count)
    );

    // Readiness depends only on FIFO state; a same-cycle pop never frees a slot.
    assign cmd_ready  = (fifo_count != CW'(DEPTH));
    assign fifo_push  = cmd_valid && cmd_ready;
    assign push_entry = {cmd_sel, cmd_b, cmd_a};
    assign head_valid = (fifo_count != '0);
    assign count      = fifo_count;

    // ALU operands come from the head entry, forced to zero when empty.
    assign alu_a   = head_valid ? head[WIDTH-1:0]       : '0;
    assign alu_b   = head_valid ? head[2*WIDTH-1:WIDTH] : '0;
    assign alu_sel = head_valid ? head[EW-1:2*WIDTH]    : '0;

    // Result-register FSM: capture the ALU output whenever the slot is free or being drained.
    always_comb begin
        state_d   = state_q;
        res_y_d   = res_y_q;
        res_sel_d = res_sel_q;
        capture   = 1'b0;
        case (state_q)
            RES_EMPTY: begin
                if (head_valid) begin
                    capture = 1'b1;
                    state_d = RES_FULL;
                end
            end
            RES_FULL: begin
                if (res_ready) begin
                    if (head_valid) capture = 1'b1;
                    else            state_d = RES_EMPTY;
                end
            end
            default: state_d = RES_EMPTY;
        endcase
        fifo_pop = capture;
        if (capture) begin
            res_y_d   = alu_y;
            res_sel_d = alu_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RES_EMPTY;
            res_y_q   <= '0;
            res_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            res_y_q   <= res_y_d;
            res_sel_q <= res_sel_d;
        end
    end

    assign res_valid = (state_q == RES_FULL);
    assign res_y     = res_y_q;
    assign res_sel   = res_sel_q;

`ifdef ALU_ISSUE_FLAGS_EN
    logic res_zero_q, res_zero_d;
    logic res_neg_q, res_neg_d;

    // Flags are captured with the result and held alongside it.
    always_comb begin
        res_zero_d = res_zero_q;
        res_neg_d  = res_neg_q;
        if (capture) begin
            res_zero_d = (alu_y == '0);
            res_neg_d  = alu_y[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero_q <= 1'b0;
            res_neg_q  <= 1'b0;
        end else begin
            res_zero_q <= res_zero_d;
            res_neg_q  <= res_neg_d;
        end
    end

    assign res_zero = res_zero_q;
    assign res_neg  = res_neg_q;
`endif

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a stand-in for alu_simple,
// a scoreboard of expected results and directed latency/capacity/reset checks.
module tb_alu_issue_stage;

    localparam int unsigned W = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [1:0]    cmd_sel;
    logic [W-1:0]  alu_a, alu_b;
    logic [1:0]    alu_sel;
    logic [W-1:0]  alu_y;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_y;
    logic [1:0]    res_sel;
    logic [2:0]    count;
`ifdef ALU_ISSUE_FLAGS_EN
    logic          res_zero, res_neg;
`endif

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q [$];   // {sel, y}
    bit rnd_done;

    alu_issue_stage #(.WIDTH(W), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_sel   (res_sel),
        .count     (count)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .res_zero  (res_zero),
        .res_neg   (res_neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external combinational alu_simple.
    always_comb begin
        case (alu_sel)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = alu_a & alu_b;
            default: alu_y = alu_a | alu_b;
        endcase
    end

    // Reference result from plain integer arithmetic reduced modulo 2^16.
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] sel);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (sel)
            2'b00:   r = (ia + ib) % 65536;
            2'b01:   r = (ia - ib + 65536) % 65536;
            2'b10:   r = ia & ib;
            default: r = ia | ib;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard producer: every accepted command yields one expected result.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready)
            exp_q.push_back({cmd_sel, ref_alu(cmd_a, cmd_b, cmd_sel)});
    end

    // Scoreboard consumer: compare each result as it is handed downstream.
    logic [17:0] got;
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_y), 32'hFFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                check("sb_res_y", 32'(res_y), 32'(got[15:0]));
                check("sb_res_sel", 32'(res_sel), 32'(got[17:16]));
            end
        end
    end

    // Held result must not change while downstream stalls.
    bit          prev_hold;
    logic [17:0] prev_res;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_res", 32'({res_sel, res_y}), 32'(prev_res));
            end
            prev_hold = res_valid && !res_ready;
            prev_res  = {res_sel, res_y};
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
        bit acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 required=1");
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
        check("drain_idle", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int acc_n;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        res_ready = 1'b0;
        rnd_done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_y", 32'(res_y), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_drive", 32'({alu_sel, alu_b, alu_a}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Back-to-back opcodes with 2-edge latency on the first.
        res_ready = 1'b1;
        send(16'd15, 16'd4, 2'b00);
        check("lat_not_yet", 32'(res_valid), 32'd0);
        check("lat_count", 32'(count), 32'd1);
        send(16'd15, 16'd4, 2'b01);
        check("lat_valid", 32'(res_valid), 32'd1);
        check("seq_add", 32'(res_y), 32'd19);
        send(16'd15, 16'd4, 2'b10);
        check("seq_sub", 32'(res_y), 32'd11);
        send(16'd15, 16'd4, 2'b11);
        check("seq_and", 32'(res_y), 32'd4);
        step();
        check("seq_or", 32'(res_y), 32'd15);
        check("seq_or_sel", 32'(res_sel), 32'd3);
        step();
        check("seq_empty", 32'(res_valid), 32'd0);

        // Modular wrap of add and sub.
        send(16'h0F0F, 16'h00FF, 2'b00);
        send(16'h0000, 16'h0001, 2'b01);
        check("wrap_add", 32'(res_y), 32'h100E);
        step();
        check("wrap_sub", 32'(res_y), 32'hFFFF);
`ifdef ALU_ISSUE_FLAGS_EN
        check("neg_flag", 32'(res_neg), 32'd1);
        check("neg_zero", 32'(res_zero), 32'd0);
        send(16'd5, 16'd5, 2'b01);
        step();
        check("zero_flag", 32'(res_zero), 32'd1);
        check("zero_neg", 32'(res_neg), 32'd0);
`endif
        drain();

        // Capacity with downstream stalled, then release one result per pulse.
        res_ready = 1'b0;
        acc_n     = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = W'($urandom);
            cmd_b     = W'($urandom);
            cmd_sel   = 2'($urandom);
            @(negedge clk);
            if (cmd_ready) acc_n++;
            step();
        end
        cmd_valid = 1'b0;
        check("cap_accepted", 32'(acc_n), 32'd5);
        check("cap_count", 32'(count), 32'd4);
        check("cap_ready_low", 32'(cmd_ready), 32'd0);
        check("cap_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check("pulse_count", 32'(count), 32'(i < 4 ? 3 - i : 0));
            check("pulse_ready", 32'(cmd_ready), 32'd1);
            check("pulse_valid", 32'(res_valid), 32'(i < 4 ? 1 : 0));
        end
        check("cap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with entries queued.
        send(16'd1, 16'd2, 2'b00);
        send(16'd3, 16'd4, 2'b00);
        send(16'd5, 16'd6, 2'b00);
        send(16'd7, 16'd8, 2'b00);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_valid", 32'(res_valid), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_y", 32'({res_sel, res_y}), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_alu", 32'({alu_sel, alu_b, alu_a}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        send(16'd100, 16'd23, 2'b00);
        check("post_rst_lat0", 32'(res_valid), 32'd0);
        step();
        check("post_rst_lat1", 32'(res_valid), 32'd1);
        check("post_rst_y", 32'(res_y), 32'd123);
        drain();

        // Randomised traffic with random downstream back-pressure.
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send(W'($urandom), W'($urandom), 2'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    res_ready = 1'($urandom);
                    step();
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_issue_stage
